// File: rtl/shared_ptw.sv
// shared_ptw: round-robin page-table walker shared by NUM_PORTS TLB miss
// channels behind one cache read port. Walks LEVELS-deep Sv39/Sv48 tables
// rooted at satp and returns the leaf PTE with its level, or a fault.
//
// Build option: define SHARED_PTW_SUPERPAGE_EN to accept aligned superpage
// leaves at levels above 0. Without it every leaf above level 0 faults and
// resp_level is always 0.
//
// Handshake: an idle walker picks the next requester after last_grant and
// raises req_ready for that port for one cycle; the request transfers at the
// clock edge that ends that cycle (req_valid high, req_ready high, busy low).
// The granted port later sees exactly one resp_valid pulse, unless the walk
// is aborted by flush or reset, in which case it must re-request.
module shared_ptw #(
  parameter int NUM_PORTS  = 2,
  parameter int LEVELS     = 3,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int PPN_WIDTH  = 44
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            flush,
  input  logic [DATA_WIDTH-1:0]           satp,
  input  logic [NUM_PORTS-1:0]            req_valid,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_va,
  output logic [NUM_PORTS-1:0]            req_ready,
  output logic [NUM_PORTS-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]           resp_pte,
  output logic [1:0]                      resp_level,
  output logic                            resp_fault,
  output logic                            mem_ren,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  input  logic                            mem_stall,
  output logic                            busy
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, WALK, DRAIN, RESP} state_t;

  state_t                state;
  logic [PW-1:0]         grant_idx;
  logic [PW-1:0]         last_grant;
  logic [ADDR_WIDTH-1:0] va_q;
  logic [PPN_WIDTH-1:0]  base_ppn;
  logic [1:0]            level_q;

  // Round-robin pick: first valid port strictly after last_grant.
  logic [PW-1:0] arb_idx;
  logic          arb_hit;
  int            arb_cand;
  always_comb begin
    arb_idx  = '0;
    arb_hit  = 1'b0;
    arb_cand = 0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      arb_cand = (int'(last_grant) + i) % NUM_PORTS;
      if (!arb_hit && req_valid[arb_cand]) begin
        arb_hit = 1'b1;
        arb_idx = PW'(arb_cand);
      end
    end
  end

  // PTE address for the current level, built only from registered walk state.
  logic [ADDR_WIDTH-1:0] va_shift;
  logic [ADDR_WIDTH-1:0] table_base;
  logic [ADDR_WIDTH-1:0] pte_offset;
  logic [8:0]            vpn_cur;
  always_comb begin
    va_shift   = va_q >> (12 + 9 * int'(level_q));
    vpn_cur    = va_shift[8:0];
    table_base = ADDR_WIDTH'({base_ppn, 12'b0});
    pte_offset = ADDR_WIDTH'({vpn_cur, 3'b000});
  end
  assign mem_addr = mem_ren ? (table_base + pte_offset) : '0;

  // Decode of the PTE returned by the cache this cycle.
  logic                 pte_bad;
  logic                 pte_leaf;
  logic                 leaf_ok;
  logic [1:0]           leaf_level;
  logic [PPN_WIDTH-1:0] pte_ppn;
`ifdef SHARED_PTW_SUPERPAGE_EN
  logic [PPN_WIDTH-1:0] sp_mask;
`endif
  always_comb begin
    pte_ppn  = mem_rdata[PPN_WIDTH+9:10];
    pte_bad  = !mem_rdata[0] || (!mem_rdata[1] && mem_rdata[2]);
    pte_leaf = mem_rdata[1] || mem_rdata[3];
`ifdef SHARED_PTW_SUPERPAGE_EN
    // A superpage leaf must have its PPN bits below the leaf level cleared.
    sp_mask    = ~({PPN_WIDTH{1'b1}} << (9 * int'(level_q)));
    leaf_ok    = (level_q == 2'd0) || ((pte_ppn & sp_mask) == '0);
    leaf_level = level_q;
`else
    leaf_ok    = (level_q == 2'd0);
    leaf_level = 2'd0;
`endif
  end

  // satp mode/ASID fields are not used by the walk itself.
  logic unused_satp;
  assign unused_satp = ^satp[DATA_WIDTH-1:PPN_WIDTH];

  // Walker FSM; all handshake and response outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      grant_idx  <= '0;
      last_grant <= PW'(NUM_PORTS - 1);
      va_q       <= '0;
      base_ppn   <= '0;
      level_q    <= '0;
      req_ready  <= '0;
      resp_valid <= '0;
      resp_pte   <= '0;
      resp_level <= '0;
      resp_fault <= 1'b0;
      mem_ren    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      req_ready  <= '0;
      resp_valid <= '0;
      case (state)
        IDLE: begin
          if (req_ready != '0) begin
            // Transfer edge: capture the granted request and start at the root.
            va_q       <= req_va[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            base_ppn   <= satp[PPN_WIDTH-1:0];
            level_q    <= 2'(LEVELS - 1);
            last_grant <= grant_idx;
            mem_ren    <= 1'b1;
            busy       <= 1'b1;
            state      <= WALK;
          end else if (arb_hit) begin
            req_ready <= NUM_PORTS'(1) << arb_idx;
            grant_idx <= arb_idx;
          end
        end
        WALK: begin
          if (!mem_stall) begin
            if (flush) begin
              mem_ren <= 1'b0;
              busy    <= 1'b0;
              state   <= IDLE;
            end else if (pte_bad || (pte_leaf && !leaf_ok) ||
                         (!pte_leaf && level_q == 2'd0)) begin
              resp_valid <= NUM_PORTS'(1) << grant_idx;
              resp_pte   <= '0;
              resp_level <= 2'd0;
              resp_fault <= 1'b1;
              mem_ren    <= 1'b0;
              state      <= RESP;
            end else if (pte_leaf) begin
              resp_valid <= NUM_PORTS'(1) << grant_idx;
              resp_pte   <= mem_rdata;
              resp_level <= leaf_level;
              resp_fault <= 1'b0;
              mem_ren    <= 1'b0;
              state      <= RESP;
            end else begin
              base_ppn <= pte_ppn;
              level_q  <= level_q - 2'd1;
            end
          end else if (flush) begin
            // The cache still owes us this read; let it finish before idling.
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!mem_stall) begin
            mem_ren <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          mem_ren <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_ptw.sv
// tb_shared_ptw: table-driven walks plus hand-written stall, flush,
// round-robin and reset sequences for shared_ptw. The bench plays the cache
// from a queue of scripted PTEs and tracks the expected PTE address itself.
`timescale 1ns/1ps
module tb_shared_ptw;
  localparam int NP = 2;
  localparam int LV = 3;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int PN = 44;

  localparam logic [63:0] VA_A = 64'h0000_0040_1234_5000;
  localparam logic [63:0] VA_B = 64'h0000_0000_5234_5000;

  logic            clk = 1'b0;
  logic            rstn;
  logic            flush;
  logic [DW-1:0]   satp;
  logic [NP-1:0]   req_valid;
  logic [NP*AW-1:0] req_va;
  logic [NP-1:0]   req_ready;
  logic [NP-1:0]   resp_valid;
  logic [DW-1:0]   resp_pte;
  logic [1:0]      resp_level;
  logic            resp_fault;
  logic            mem_ren;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_rdata;
  logic            mem_stall;
  logic            busy;

  shared_ptw #(.NUM_PORTS(NP), .LEVELS(LV), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
               .PPN_WIDTH(PN)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .satp(satp),
    .req_valid(req_valid), .req_va(req_va), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_pte(resp_pte), .resp_level(resp_level),
    .resp_fault(resp_fault), .mem_ren(mem_ren), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall), .busy(busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [3:0]  port;
    logic [63:0] pte;
    logic [1:0]  lvl;
    logic        fault;
    logic [7:0]  lat;
  } exp_t;

  typedef struct {
    int          port;
    logic [63:0] va;
    int          nrd;
    logic [63:0] p0, p1, p2;
    logic [63:0] pte;
    logic [1:0]  lvl;
    logic        fault;
  } vec_t;

  exp_t        exp_q[$];
  int          grant_q[$];
  logic [63:0] script_q[$];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          grant_cyc = 0;
  int          grants_seen = 0;
  int          reads_done = 0;
  int          accept_port = -1;
  logic [NP-1:0] hold = '0;

  // cache-side address model
  logic [43:0] m_base;
  logic [63:0] m_va;
  int          m_lvl;

  function automatic logic [63:0] mk(input logic [43:0] ppn, input logic [9:0] flags);
    return {10'b0, ppn, flags};
  endfunction
  function automatic logic [63:0] ptr(input logic [43:0] ppn);
    return mk(ppn, 10'h001);
  endfunction
  function automatic logic [63:0] leaf(input logic [43:0] ppn);
    return mk(ppn, 10'h0CF);
  endfunction

  function automatic logic [63:0] model_addr();
    logic [63:0] sh;
    sh = m_va >> (12 + 9 * m_lvl);
    return {8'b0, m_base, 12'b0} + {52'b0, sh[8:0], 3'b000};
  endfunction

  function automatic int onehot_idx(input logic [NP-1:0] v);
    for (int i = 0; i < NP; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // scoreboard: compare grants and responses as the DUT produces them
  task automatic monitor();
    int   g;
    exp_t e;
    if (accept_port >= 0) begin
      if (!hold[accept_port]) req_valid[accept_port] = 1'b0;
      accept_port = -1;
    end
    if (req_ready != '0) begin
      g = onehot_idx(req_ready);
      check("ready_onehot", 64'($countones(req_ready)), 64'd1);
      check("ready_not_busy", {63'b0, busy}, 64'd0);
      if (grant_q.size() == 0) check("grant_unexpected", {62'b0, req_ready}, 64'd0);
      else check("grant_port", 64'(g), 64'(grant_q.pop_front()));
      accept_port = g;
      grant_cyc   = cyc;
      grants_seen++;
      m_base      = satp[43:0];
      m_lvl       = LV - 1;
      m_va        = req_va[g*AW +: AW];
      reads_done  = 0;
    end
    if (resp_valid != '0) begin
      if (exp_q.size() == 0) check("resp_unexpected", {62'b0, resp_valid}, 64'd0);
      else begin
        e = exp_q.pop_front();
        check("resp_port", {62'b0, resp_valid}, 64'd1 << e.port);
        check("resp_fault", {63'b0, resp_fault}, {63'b0, e.fault});
        check("resp_pte", resp_pte, e.pte);
        if (!e.fault) check("resp_level", {62'b0, resp_level}, {62'b0, e.lvl});
        check("resp_latency", 64'(cyc - grant_cyc), {56'b0, e.lat});
      end
    end
  endtask

  // driver: serve the cache read for the coming edge, clock, then observe
  task automatic tick();
    logic        consume;
    logic [63:0] pte;
    consume = 1'b0;
    if (mem_ren === 1'b1) begin
      check("mem_addr", mem_addr, model_addr());
      if (script_q.size() == 0) begin
        check("script_underrun", 64'd0, 64'd1);
        mem_rdata = '0;
      end else begin
        mem_rdata = script_q[0];
        consume   = !mem_stall;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (consume) begin
      pte    = script_q.pop_front();
      m_base = pte[53:10];
      if (m_lvl > 0) m_lvl--;
      reads_done++;
    end
    monitor();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || grant_q.size() != 0 || busy !== 1'b0 || req_valid != '0)
           && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(exp_q.size() + grant_q.size()), 64'd0);
  endtask

  task automatic expect_resp(input int port, input logic [63:0] pte, input logic [1:0] lvl,
                             input logic fault, input int lat);
    exp_t e;
    e.port  = 4'(port);
    e.pte   = pte;
    e.lvl   = lvl;
    e.fault = fault;
    e.lat   = 8'(lat);
    exp_q.push_back(e);
  endtask

  vec_t vecs[10];

  initial begin
    int n;
    rstn = 1'b0; flush = 1'b0; mem_stall = 1'b0; mem_rdata = '0;
    req_valid = '0; req_va = '0;
    satp = 64'h8000_0000_0008_0000;
    m_base = '0; m_va = '0; m_lvl = 0;

    // reset state
    tick(); tick();
    check("rst_req_ready", {62'b0, req_ready}, 64'd0);
    check("rst_resp_valid", {62'b0, resp_valid}, 64'd0);
    check("rst_mem_ren", {63'b0, mem_ren}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_resp_fault", {63'b0, resp_fault}, 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_resp_pte", resp_pte, 64'd0);
    check("rst_resp_level", {62'b0, resp_level}, 64'd0);
    rstn = 1'b1;

    // round-robin: both ports held for three walks, grants 0,1,0
    script_q.push_back(ptr(44'h80001)); script_q.push_back(ptr(44'h80002));
    script_q.push_back(64'h2000_04CF);
    script_q.push_back(64'h0);
    script_q.push_back(64'hCE);
    expect_resp(0, 64'h2000_04CF, 2'd0, 1'b0, 4);
    expect_resp(1, 64'h0, 2'd0, 1'b1, 2);
    expect_resp(0, 64'h0, 2'd0, 1'b1, 2);
    grant_q.push_back(0); grant_q.push_back(1); grant_q.push_back(0);
    req_va[0 +: AW] = VA_A; req_va[AW +: AW] = VA_B;
    hold = '1; req_valid = '1; grants_seen = 0;
    n = 0;
    while (grants_seen < 3 && n < 200) begin tick(); n++; end
    tick();
    hold = '0; req_valid = '0;
    wait_idle("round_robin", 200);

    // table of single walks with zero-stall cache
    vecs[0] = '{0, VA_A, 3, ptr(44'h80001), ptr(44'h80002), 64'h2000_04CF,
                64'h2000_04CF, 2'd0, 1'b0};
    vecs[1] = '{1, VA_B, 3, ptr(44'h80003), ptr(44'h80004), leaf(44'h12345),
                leaf(44'h12345), 2'd0, 1'b0};
    vecs[2] = '{0, VA_B, 1, 64'hCE, 64'h0, 64'h0, 64'h0, 2'd0, 1'b1};
    vecs[3] = '{1, VA_A, 3, ptr(44'h80005), ptr(44'h80006), ptr(44'h80007),
                64'h0, 2'd0, 1'b1};
    vecs[4] = '{0, VA_A, 2, ptr(44'h80008), mk(44'h80009, 10'h005), 64'h0,
                64'h0, 2'd0, 1'b1};
`ifdef SHARED_PTW_SUPERPAGE_EN
    vecs[5] = '{1, VA_B, 2, ptr(44'h80010), leaf(44'h80200), 64'h0,
                leaf(44'h80200), 2'd1, 1'b0};
    vecs[7] = '{1, VA_A, 1, leaf(44'h40000), 64'h0, 64'h0,
                leaf(44'h40000), 2'd2, 1'b0};
`else
    vecs[5] = '{1, VA_B, 2, ptr(44'h80010), leaf(44'h80200), 64'h0,
                64'h0, 2'd0, 1'b1};
    vecs[7] = '{1, VA_A, 1, leaf(44'h40000), 64'h0, 64'h0,
                64'h0, 2'd0, 1'b1};
`endif
    vecs[6] = '{0, VA_B, 2, ptr(44'h80011), leaf(44'h80201), 64'h0,
                64'h0, 2'd0, 1'b1};
    vecs[8] = '{0, VA_B, 3, ptr(44'h80012), ptr(44'h80013), mk(44'h80123, 10'h009),
                mk(44'h80123, 10'h009), 2'd0, 1'b0};
    vecs[9] = '{1, VA_A, 3, ptr(44'h80014), ptr(44'h80015), mk(44'h80124, 10'h00D),
                64'h0, 2'd0, 1'b1};
    foreach (vecs[i]) begin
      script_q.push_back(vecs[i].p0);
      if (vecs[i].nrd > 1) script_q.push_back(vecs[i].p1);
      if (vecs[i].nrd > 2) script_q.push_back(vecs[i].p2);
      grant_q.push_back(vecs[i].port);
      expect_resp(vecs[i].port, vecs[i].pte, vecs[i].lvl, vecs[i].fault, vecs[i].nrd + 1);
      req_va[vecs[i].port*AW +: AW] = vecs[i].va;
      req_valid[vecs[i].port] = 1'b1;
      wait_idle($sformatf("vec%0d_done", i), 60);
    end

    // five stall cycles on the second read delay the response by five
    script_q.push_back(ptr(44'h80021)); script_q.push_back(ptr(44'h80022));
    script_q.push_back(leaf(44'h80023));
    grant_q.push_back(0);
    expect_resp(0, leaf(44'h80023), 2'd0, 1'b0, 9);
    reads_done = 0;
    req_va[0 +: AW] = VA_A; req_valid[0] = 1'b1;
    n = 0;
    while (reads_done < 1 && n < 20) begin tick(); n++; end
    mem_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_ren", {63'b0, mem_ren}, 64'd1);
    end
    mem_stall = 1'b0;
    wait_idle("stall_done", 40);

    // flush while stalled: drain the read, then idle with no response
    script_q.push_back(ptr(44'h80031)); script_q.push_back(ptr(44'h80032));
    grant_q.push_back(1);
    reads_done = 0;
    req_va[AW +: AW] = VA_B; req_valid[1] = 1'b1;
    n = 0;
    while (reads_done < 1 && n < 20) begin tick(); n++; end
    mem_stall = 1'b1;
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("drain_ren", {63'b0, mem_ren}, 64'd1);
      check("drain_busy", {63'b0, busy}, 64'd1);
    end
    mem_stall = 1'b0;
    tick();
    check("drain_end_ren", {63'b0, mem_ren}, 64'd0);
    check("drain_end_busy", {63'b0, busy}, 64'd0);
    for (int k = 0; k < 6; k++) tick();
    wait_idle("flush_stall_done", 20);

    // flush with the cache answering: abort at that edge
    script_q.push_back(ptr(44'h80041)); script_q.push_back(ptr(44'h80042));
    grant_q.push_back(0);
    reads_done = 0;
    req_va[0 +: AW] = VA_A; req_valid[0] = 1'b1;
    n = 0;
    while (reads_done < 1 && n < 20) begin tick(); n++; end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_ren", {63'b0, mem_ren}, 64'd0);
    check("flush_busy", {63'b0, busy}, 64'd0);
    for (int k = 0; k < 5; k++) tick();
    wait_idle("flush_done", 20);

    // reset mid-walk abandons the read; port 0 wins the first grant after
    script_q.push_back(ptr(44'h80051)); script_q.push_back(ptr(44'h80052));
    script_q.push_back(ptr(44'h80053));
    grant_q.push_back(1);
    req_va[AW +: AW] = VA_A; req_valid[1] = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin tick(); n++; end
    tick();
    rstn = 1'b0;
    tick();
    check("midrst_ren", {63'b0, mem_ren}, 64'd0);
    check("midrst_busy", {63'b0, busy}, 64'd0);
    check("midrst_resp", {62'b0, resp_valid}, 64'd0);
    rstn = 1'b1;
    script_q.delete();
    req_valid = '0;
    script_q.push_back(64'h0); script_q.push_back(64'h0);
    grant_q.push_back(0); grant_q.push_back(1);
    expect_resp(0, 64'h0, 2'd0, 1'b1, 2);
    expect_resp(1, 64'h0, 2'd0, 1'b1, 2);
    req_va[0 +: AW] = VA_B; req_va[AW +: AW] = VA_A;
    req_valid = '1;
    wait_idle("after_reset_done", 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
